// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned IMM_W            = 16;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc4;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: imem request/response, redirect input and decode handshake.
interface fetch_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [INSTR_W-1:0] imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [INSTR_W-1:0] redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [INSTR_W-1:0] id_pc4;
    logic [IMM_W-1:0]   id_imm16;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc4, id_imm16,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc4, id_imm16,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction buffer of {instr, pc4}; flush wins over push, head is read from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, credit-limits imem requests, drains stale responses on redirect.
// Defining FETCH_STATS_EN adds the stat_fetched / stat_dropped counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_if.master     bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
`endif
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_next;
    logic [INSTR_W-1:0] rsp_pc;
    logic [INSTR_W-1:0] rsp_pc_next;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   drop_cnt_next;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_valid;
    logic               req_fire;
    logic               drop;
    logic               push;
    logic               pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    assign bus.imem_req_valid = rst_n && (state == FETCH) && !bus.redirect_valid
                             && ((32'(outstanding) + 32'(fifo_count)) < FIFO_DEPTH);
    assign bus.imem_req_addr  = pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign drop     = bus.imem_rsp_valid && (bus.redirect_valid || drop_cnt != '0);
    assign push     = bus.imem_rsp_valid && !drop;
    assign pop      = fifo_valid && bus.id_ready;

    // Surviving responses always belong to requests issued since the last redirect, so
    // their addresses are sequential from the redirect target; rsp_pc tracks that in place
    // of a per-request tag queue.
    assign push_entry.instr = bus.imem_rsp_data;
    assign push_entry.pc4   = rsp_pc + PC_INC;

    always_comb begin
        pc_next          = pc;
        rsp_pc_next      = rsp_pc;
        outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        drop_cnt_next    = drop_cnt;

        if (bus.redirect_valid) begin
            pc_next     = align_word(bus.redirect_pc);
            rsp_pc_next = align_word(bus.redirect_pc);
        end else begin
            if (req_fire) pc_next = pc + PC_INC;
            if (push)     rsp_pc_next = rsp_pc + PC_INC;
        end

        if (bus.redirect_valid && state == FETCH) begin
            drop_cnt_next = outstanding - CNT_W'(bus.imem_rsp_valid);
        end else if (drop) begin
            drop_cnt_next = drop_cnt - CNT_W'(1);
        end

        state_next = (drop_cnt_next != '0) ? DRAIN : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign bus.id_valid = fifo_valid;
    assign bus.id_instr = head.instr;
    assign bus.id_pc4   = head.pc4;
    assign bus.id_imm16 = head.instr[IMM_W-1:0];

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            if (push) stat_fetched <= stat_fetched + 32'd1;
            if (drop) stat_dropped <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and an
// architectural stream model (delivered words run sequentially from the last redirect target).
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_dropped;
`endif

    fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_dropped (stat_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pending[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc;
    int unsigned req_count = 0;
    int unsigned pop_count = 0;
    int unsigned rsp_count = 0;
    int          mem_ready_mode = 1;
    int unsigned mem_lat = 1;
    int unsigned mem_lat_rand = 0;
    bit          mem_hold = 1'b0;
    logic [31:0] m_req_pc;
    logic [31:0] m_exp_pc;
    bit          prev_hold;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc4;
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_id_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc4;
    logic [15:0] s_imm;
    logic        s_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_FFD5;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    task automatic model_reset();
        pending.delete();
        m_req_pc  = RPC;
        m_exp_pc  = RPC;
        prev_hold = 1'b0;
        cyc       = 0;
        rsp_count = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic [31:0] exp_w;
        bus.imem_req_ready = (mem_ready_mode == 1) ||
                             (mem_ready_mode == 2 && $urandom_range(0, 9) < 7);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (!mem_hold && pending.size() > 0 && pending[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pending[0].addr);
            void'(pending.pop_front());
            rsp_count++;
        end
        #1;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_id_valid  = bus.id_valid;
        s_instr     = bus.id_instr;
        s_pc4       = bus.id_pc4;
        s_imm       = bus.id_imm16;
        s_pop       = s_id_valid && bus.id_ready;

        checks++;
        if (s_req_addr !== m_req_pc) begin
            errors++;
            $display("FAIL req_addr cyc=%0d got %h want %h", cyc, s_req_addr, m_req_pc);
        end
        if (bus.redirect_valid) begin
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_during_redirect cyc=%0d got %b want 0", cyc, s_req_valid);
            end
        end
        if (prev_hold) begin
            checks++;
            if (s_id_valid !== 1'b1 || s_instr !== prev_instr || s_pc4 !== prev_pc4) begin
                errors++;
                $display("FAIL id_stable cyc=%0d got %b/%h/%h want 1/%h/%h",
                         cyc, s_id_valid, s_instr, s_pc4, prev_instr, prev_pc4);
            end
        end
        if (s_pop) begin
            exp_w = mem_word(m_exp_pc);
            checks++;
            if (s_instr !== exp_w || s_pc4 !== m_exp_pc + 32'd4 || s_imm !== exp_w[15:0]) begin
                errors++;
                $display("FAIL pop_data cyc=%0d got %h/%h/%h want %h/%h/%h",
                         cyc, s_instr, s_pc4, s_imm, exp_w, m_exp_pc + 32'd4, exp_w[15:0]);
            end
            m_exp_pc = m_exp_pc + 32'd4;
            pop_count++;
        end
        if (s_req_valid === 1'b1 && bus.imem_req_ready) begin
            pending.push_back('{addr: s_req_addr, due: cyc + mem_lat + $urandom_range(0, mem_lat_rand)});
            m_req_pc = m_req_pc + 32'd4;
            req_count++;
            checks++;
            if (pending.size() > DEPTH) begin
                errors++;
                $display("FAIL credit cyc=%0d got %0d outstanding want <= %0d", cyc, pending.size(), DEPTH);
            end
        end
        if (bus.redirect_valid) begin
            m_req_pc = bus.redirect_pc & ~32'd3;
            m_exp_pc = bus.redirect_pc & ~32'd3;
        end
        prev_hold  = s_id_valid && !bus.id_ready && !bus.redirect_valid;
        prev_instr = s_instr;
        prev_pc4   = s_pc4;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got %b/%b want 0/0", bus.imem_req_valid, bus.id_valid);
        end
        checks++;
        if (bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0 || bus.id_imm16 !== 16'h0) begin
            errors++;
            $display("FAIL reset_id got %h/%h/%h want 0/0/0", bus.id_instr, bus.id_pc4, bus.id_imm16);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        logic [31:0] sext;
        mem_ready_mode = 1;
        mem_lat = 1;
        mem_lat_rand = 0;
        bus.id_ready = 1'b0;
        cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL first_req got %b/%h want 1/00400000", s_req_valid, s_req_addr);
        end
        cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL second_req got %b/%h want 1/00400004", s_req_valid, s_req_addr);
        end
        cycle();
        sext = {{16{s_imm[15]}}, s_imm};
        checks++;
        if (s_id_valid !== 1'b1 || s_instr !== 32'h2008_FFD5 || s_pc4 !== 32'h0040_0004) begin
            errors++;
            $display("FAIL first_word got %b/%h/%h want 1/2008ffd5/00400004", s_id_valid, s_instr, s_pc4);
        end
        checks++;
        if (s_imm !== 16'hFFD5 || sext !== 32'hFFFF_FFD5) begin
            errors++;
            $display("FAIL imm16 got %h/%h want ffd5/ffffffd5", s_imm, sext);
        end
    endtask

    task automatic test_backpressure();
        int unsigned start;
        bus.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_no_req step=%0d got %b want 0", i, s_req_valid);
            end
        end
        start = req_count;
        bus.id_ready = 1'b1;
        cycle();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (req_count - start !== 1) begin
            errors++;
            $display("FAIL one_pop_one_req got %0d want 1", req_count - start);
        end
    endtask

    task automatic test_redirect_drain();
        bit got;
        bus.id_ready = 1'b1;
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && pending.size() != DEPTH; i++) cycle();
        checks++;
        if (pending.size() != DEPTH) begin
            errors++;
            $display("FAIL drain_setup got %0d outstanding want %0d", pending.size(), DEPTH);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0100;
        cycle();
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_no_req step=%0d got %b want 0", i, s_req_valid);
            end
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            got = s_pop;
        end
        checks++;
        if (!got || s_instr !== mem_word(32'h0040_0100) || s_pc4 !== 32'h0040_0104) begin
            errors++;
            $display("FAIL drain_first_word got %b/%h/%h want 1/%h/00400104",
                     got, s_instr, s_pc4, mem_word(32'h0040_0100));
        end
    endtask

    task automatic test_redirect_same_rsp();
        bus.id_ready = 1'b1;
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && pending.size() != DEPTH; i++) cycle();
        mem_hold = 1'b0;
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0040_0203;
        cycle();
        bus.redirect_valid = 1'b0;
        checks++;
        if (s_req_valid !== 1'b0 || s_pop !== 1'b1) begin
            errors++;
            $display("FAIL redirect_cycle got req=%b pop=%b want req=0 pop=1", s_req_valid, s_pop);
        end
        cycle();
        checks++;
        if (s_id_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0040_0200) begin
            errors++;
            $display("FAIL after_same_rsp got %b/%b/%h want 0/1/00400200", s_id_valid, s_req_valid, s_req_addr);
        end
        for (int i = 0; i < 8; i++) cycle();
    endtask

    task automatic test_async_reset();
        mem_ready_mode = 1;
        bus.id_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (s_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b want 1", s_id_valid);
        end
        #3;
        rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (bus.id_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.id_instr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%h want 0/0/0", bus.id_valid, bus.imem_req_valid, bus.id_instr);
        end
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cycle();
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RPC) begin
            errors++;
            $display("FAIL restart got %b/%h want 1/%h", s_req_valid, s_req_addr, RPC);
        end
    endtask

    task automatic test_random();
        int unsigned start_pops;
        start_pops = pop_count;
        mem_ready_mode = 2;
        mem_lat = 1;
        mem_lat_rand = 3;
        for (int i = 0; i < 3000; i++) begin
            bus.id_ready = ($urandom_range(0, 3) != 0);
            mem_hold = ($urandom_range(0, 9) == 0);
            bus.redirect_valid = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else
                bus.redirect_pc = RPC + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            cycle();
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (pop_count - start_pops < 300) begin
            errors++;
            $display("FAIL random_progress got %0d pops want >= 300", pop_count - start_pops);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (stat_fetched + stat_dropped !== 32'(rsp_count)) begin
            errors++;
            $display("FAIL stats_total got %0d want %0d", stat_fetched + stat_dropped, rsp_count);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_rsp();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
